// File: rtl/coprocessor_pkg.sv
// Shared definitions for the matrix coprocessor: default geometry, matrix
// select and access-type encodings, and the loader FSM state encoding.
package coprocessor_pkg;

  localparam int unsigned DEFAULT_SIZE       = 10;
  localparam int unsigned DEFAULT_CELL_WIDTH = 32;

  typedef enum logic [1:0] {
    SEL_A       = 2'b00,
    SEL_B       = 2'b01,
    SEL_C       = 2'b10,
    SEL_ILLEGAL = 2'b11
  } matrix_sel_e;

  typedef enum logic [1:0] {
    ACCESS_COLUMN = 2'b00,
    ACCESS_ROW    = 2'b01,
    ACCESS_THIRD  = 2'b10
  } access_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } loader_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/loader_row_buffer.sv
// Row assembly buffer for matrix_loader: collects one row of cells in
// row-major order and tracks the column position of the next cell.
module loader_row_buffer
  import coprocessor_pkg::*;
#(
  parameter int unsigned size       = DEFAULT_SIZE,
  parameter int unsigned cell_width = DEFAULT_CELL_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       accept,
  input  logic                       next_row,
  input  logic [cell_width-1:0]      cell_data,
  output logic [cell_width*size-1:0] row_data,
  output logic                       last_col
);

  localparam int unsigned COL_W = index_width(size);

  logic [COL_W-1:0]           col_q;
  logic [cell_width*size-1:0] row_q;

  assign last_col = (col_q == COL_W'(size - 1));
  assign row_data = row_q;

  // Store accepted cells into their lane; column saturates at the last lane
  // and returns to zero when the FSM moves on to the next row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      for (int unsigned j = 0; j < size; j++) begin
        if (col_q == COL_W'(j)) begin
          row_q[j*cell_width +: cell_width] <= cell_data;
        end
      end
      if (!last_col) begin
        col_q <= col_q + 1'b1;
      end
    end else if (next_row) begin
      col_q <= '0;
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Matrix loader: streams size*size cells into a row buffer and writes each
// completed row to the register file (row access type) at address row*size.
// Optional feature: define LOADER_ABORT_EN to add the in_abort input.
module matrix_loader
  import coprocessor_pkg::*;
#(
  parameter int unsigned size          = DEFAULT_SIZE,
  parameter int unsigned cell_width    = DEFAULT_CELL_WIDTH,
  parameter int unsigned address_width = $clog2(size * size)
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       in_start,
  input  logic [1:0]                 in_select_matrix,
  input  logic [cell_width-1:0]      in_cell_data,
  input  logic                       in_cell_valid,
`ifdef LOADER_ABORT_EN
  input  logic                       in_abort,
`endif
  output logic                       out_cell_ready,
  output logic [address_width-1:0]   out_address,
  output logic [cell_width*size-1:0] out_data,
  output logic [1:0]                 out_type,
  output logic [1:0]                 out_select_matrix,
  output logic                       out_write_en,
  output logic                       out_read_en,
  output logic                       out_busy,
  output logic                       out_done
);

  localparam int unsigned ROW_W = index_width(size);

  loader_state_e    state_q, state_d;
  matrix_sel_e      sel_q;
  logic [ROW_W-1:0] row_q;
  logic             last_row;
  logic             last_col;
  logic             start_load;
  logic             accept;
  logic             advance_row;

  assign last_row    = (row_q == ROW_W'(size - 1));
  assign out_read_en = 1'b0;

  loader_row_buffer #(
    .size       (size),
    .cell_width (cell_width)
  ) u_row_buffer (
    .clk       (in_clk),
    .rst_n     (in_reset),
    .clear     (start_load),
    .accept    (accept),
    .next_row  (advance_row),
    .cell_data (in_cell_data),
    .row_data  (out_data),
    .last_col  (last_col)
  );

  // FSM state register.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched target matrix and row counter; row saturates on the last row.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      sel_q <= SEL_A;
      row_q <= '0;
    end else if (start_load) begin
      sel_q <= matrix_sel_e'(in_select_matrix);
      row_q <= '0;
    end else if (advance_row && !last_row) begin
      row_q <= row_q + 1'b1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d           = state_q;
    start_load        = 1'b0;
    accept            = 1'b0;
    advance_row       = 1'b0;
    out_cell_ready    = 1'b0;
    out_write_en      = 1'b0;
    out_type          = '0;
    out_address       = '0;
    out_select_matrix = '0;
    out_busy          = 1'b0;
    out_done          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_start && (in_select_matrix != SEL_ILLEGAL)) begin
          start_load = 1'b1;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        out_busy       = 1'b1;
        out_cell_ready = 1'b1;
        if (in_cell_valid) begin
          accept = 1'b1;
          if (last_col) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        out_busy          = 1'b1;
        out_write_en      = 1'b1;
        out_type          = ACCESS_ROW;
        out_address       = address_width'(32'(row_q) * size);
        out_select_matrix = sel_q;
        advance_row       = 1'b1;
        state_d           = last_row ? ST_DONE : ST_FILL;
      end
      ST_DONE: begin
        out_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef LOADER_ABORT_EN
    // Abort overrides the normal decode, suppressing both the cell
    // handshake and any row write issued in the same cycle.
    if (in_abort && ((state_q == ST_FILL) || (state_q == ST_WRITE))) begin
      state_d           = ST_IDLE;
      accept            = 1'b0;
      advance_row       = 1'b0;
      out_cell_ready    = 1'b0;
      out_write_en      = 1'b0;
      out_type          = '0;
      out_address       = '0;
      out_select_matrix = '0;
    end
`endif
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: expected row writes and done pulses
// are queued when a load is started; a negedge monitor pops and compares.
module tb_matrix_loader;

  localparam int SZ = 10;
  localparam int CW = 32;
  localparam int AW = 7;

  logic              clk;
  logic              in_reset;
  logic              in_start;
  logic [1:0]        in_select_matrix;
  logic [CW-1:0]     in_cell_data;
  logic              in_cell_valid;
`ifdef LOADER_ABORT_EN
  logic              in_abort;
`endif
  logic              out_cell_ready;
  logic [AW-1:0]     out_address;
  logic [SZ*CW-1:0]  out_data;
  logic [1:0]        out_type;
  logic [1:0]        out_select_matrix;
  logic              out_write_en;
  logic              out_read_en;
  logic              out_busy;
  logic              out_done;

  matrix_loader #(
    .size          (SZ),
    .cell_width    (CW),
    .address_width (AW)
  ) dut (
    .in_clk            (clk),
    .in_reset          (in_reset),
    .in_start          (in_start),
    .in_select_matrix  (in_select_matrix),
    .in_cell_data      (in_cell_data),
    .in_cell_valid     (in_cell_valid),
`ifdef LOADER_ABORT_EN
    .in_abort          (in_abort),
`endif
    .out_cell_ready    (out_cell_ready),
    .out_address       (out_address),
    .out_data          (out_data),
    .out_type          (out_type),
    .out_select_matrix (out_select_matrix),
    .out_write_en      (out_write_en),
    .out_read_en       (out_read_en),
    .out_busy          (out_busy),
    .out_done          (out_done)
  );

  typedef struct {
    bit               is_done;
    logic [AW-1:0]    addr;
    logic [1:0]       sel;
    logic [SZ*CW-1:0] data;
    int               cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  bit   prev_we  = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [SZ*CW-1:0] act,
                     input logic [SZ*CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SZ*CW-1:0] row_image(input int i);
    logic [SZ*CW-1:0] d;
    d = '0;
    for (int j = 0; j < SZ; j++) d[j*CW +: CW] = CW'(16 * i + j);
    return d;
  endfunction

  // Queue expected row writes (and optionally the done pulse) for a load.
  // Timed loads assume full-rate feeding: row r written 10+11r cycles after
  // the start edge, done one cycle after the last write.
  task automatic push_load(input logic [1:0] s, input int nrows,
                           input bit with_done, input bit timed);
    exp_t e;
    for (int r = 0; r < nrows; r++) begin
      e.is_done = 0;
      e.addr    = AW'(r * SZ);
      e.sel     = s;
      e.data    = row_image(r);
      e.cyc     = timed ? start_cyc + SZ + (SZ + 1) * r : -1;
      q.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1;
      e.addr    = '0;
      e.sel     = '0;
      e.data    = '0;
      e.cyc     = timed ? start_cyc + SZ * (SZ + 1) : -1;
      q.push_back(e);
    end
  endtask

  // Monitor: compare every write or done pulse against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (in_reset) begin
      if (out_write_en || out_done) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got we=%0b done=%0b addr=%0h expected none",
                   out_write_en, out_done, out_address);
        end else begin
          e = q.pop_front();
          chk("event_kind", {out_write_en, out_done}, e.is_done ? 2'b01 : 2'b10);
          if (!e.is_done) begin
            chk("write_addr", out_address, e.addr);
            chk("write_data", out_data, e.data);
            chk("write_sel", out_select_matrix, e.sel);
            chk("write_type", out_type, 2'b01);
            chk("write_ready_low", out_cell_ready, 1'b0);
          end
          if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
        end
      end
      if (out_write_en) chk("write_pulse_single", prev_we, 1'b0);
      prev_we = out_write_en;
    end else begin
      prev_we = 0;
    end
  end

  task automatic start(input logic [1:0] s);
    in_start = 1;
    in_select_matrix = s;
    @(posedge clk);
    #1;
    in_start = 0;
    in_select_matrix = 0;
    start_cyc = cyc;
  endtask

  // Present n cells (from row-major index first) and count handshakes.
  task automatic feed(input int n, input int first, input bit alt);
    int k = 0;
    int budget = 0;
    bit ph = 1;
    bit hs;
    while (k < n && budget < 2000) begin
      in_cell_valid = alt ? ph : 1'b1;
      in_cell_data  = CW'(16 * ((first + k) / SZ) + (first + k) % SZ);
      #1;
      hs = in_cell_valid && out_cell_ready;
      @(posedge clk);
      #1;
      if (hs) k++;
      ph = !ph;
      budget++;
    end
    in_cell_valid = 0;
    if (k < n) chk("feed_timeout", k, n);
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (q.size() != 0 && budget < 500) begin
      @(posedge clk);
      budget++;
    end
    #1;
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {out_cell_ready, out_address, out_data, out_type, out_select_matrix,
               out_write_en, out_read_en, out_busy, out_done}, '0);
  endtask

  initial begin
    in_reset = 0;
    in_start = 0;
    in_select_matrix = 0;
    in_cell_data = 0;
    in_cell_valid = 0;
`ifdef LOADER_ABORT_EN
    in_abort = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    #3;
    in_reset = 1;
    @(posedge clk);
    #1;
    chk("idle_busy", out_busy, 1'b0);

    // Full-rate load of A with cycle-accurate expectations.
    start(2'b00);
    push_load(2'b00, SZ, 1, 1);
    feed(SZ * SZ, 0, 0);
    wait_drain();
    @(posedge clk);
    #1;
    chk("after_load_busy", out_busy, 1'b0);

    // Illegal select is ignored.
    start(2'b11);
    repeat (3) @(posedge clk);
    #1;
    chk("illegal_sel_busy", out_busy, 1'b0);
    chk("illegal_sel_ready", out_cell_ready, 1'b0);

    // Load B with alternating valid; a start pulse for A mid-load is ignored.
    start(2'b01);
    push_load(2'b01, SZ, 1, 0);
    fork
      feed(SZ * SZ, 0, 1);
      begin
        repeat (30) @(posedge clk);
        #1;
        in_start = 1;
        in_select_matrix = 2'b00;
        @(posedge clk);
        #1;
        in_start = 0;
        in_select_matrix = 0;
      end
    join
    wait_drain();

    // Reset after 5 cells of row 2: rows 0 and 1 written, nothing more.
    start(2'b10);
    push_load(2'b10, 2, 0, 0);
    feed(2 * SZ + 5, 0, 0);
    chk("pre_reset_busy", out_busy, 1'b1);
    #2;
    in_reset = 0;
    #1;
    chk_all_zero("mid_row_reset_outputs");
    repeat (2) @(posedge clk);
    #3;
    in_reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_resume_busy", out_busy, 1'b0);
    chk("no_resume_queue", q.size(), 0);

    // Fresh load restarts from row 0.
    start(2'b10);
    push_load(2'b10, SZ, 1, 1);
    feed(SZ * SZ, 0, 0);
    wait_drain();

`ifdef LOADER_ABORT_EN
    // Abort during the row-4 write cycle.
    start(2'b00);
    push_load(2'b00, 4, 0, 0);
    feed(5 * SZ, 0, 0);
    in_abort = 1;
    #1;
    chk("abort_write_en", out_write_en, 1'b0);
    @(posedge clk);
    #1;
    in_abort = 0;
    chk("abort_busy", out_busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_done", out_done, 1'b0);
    chk("abort_queue", q.size(), 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
